// File: rtl/sensor_pattern_gen.sv
// Transmitting end of the two-wire vehicle-presence sensor: one command emits a
// complete entry, exit or balk waveform on (a,b), followed by an all-clear guard.
module sensor_pattern_gen #(
    parameter int HOLD_W  = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         kind,
    input  logic [HOLD_W-1:0]  hold,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               cmd_err,
    output logic [COUNT_W-1:0] enter_count,
    output logic [COUNT_W-1:0] exit_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PH1   = 3'd1,
        S_PH2   = 3'd2,
        S_PH3   = 3'd3,
        S_PH4   = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    localparam logic [1:0] K_ENTRY = 2'b00;
    localparam logic [1:0] K_EXIT  = 2'b01;
    localparam logic [1:0] K_BALK  = 2'b10;
    localparam logic [1:0] K_RSVD  = 2'b11;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_t              r_state;
    logic [HOLD_W-1:0]   r_cnt;
    logic [1:0]          r_kind;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_a;
    logic                r_b;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [COUNT_W-1:0]  r_ent;
    logic [COUNT_W-1:0]  r_ext;

    state_t              w_state_nxt;
    state_t              w_succ;
    logic [HOLD_W-1:0]   w_cnt_nxt;
    logic [1:0]          w_kind_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [HOLD_W-1:0]   w_hold_eff;
    logic                w_idle_start;
    logic                w_accept;
    logic [1:0]          w_ab_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    // A zero hold would make every phase vanish, so it is stretched to one cycle.
    assign w_hold_eff   = (hold == '0) ? HOLD_W'(1) : hold;
    assign w_idle_start = (r_state == S_IDLE) && start;
    assign w_accept     = w_idle_start && (kind != K_RSVD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kind  <= K_ENTRY;
            r_hold  <= HOLD_W'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_kind  <= w_kind_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Phase order depends on the latched passage kind.
    always_comb begin
        w_succ = S_IDLE;
        unique case (r_state)
            S_PH1:   w_succ = (r_kind == K_BALK) ? S_GUARD : S_PH2;
            S_PH2:   w_succ = S_PH3;
            S_PH3:   w_succ = (r_kind == K_ENTRY) ? S_PH4 : S_GUARD;
            S_PH4:   w_succ = S_GUARD;
            S_GUARD: w_succ = S_IDLE;
            default: w_succ = S_IDLE;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kind_nxt  = r_kind;
        w_hold_nxt  = r_hold;
        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
            if (w_accept) begin
                w_state_nxt = S_PH1;
                w_cnt_nxt   = w_hold_eff - HOLD_W'(1);
                w_kind_nxt  = kind;
                w_hold_nxt  = w_hold_eff;
            end
        end else if (r_cnt == '0) begin
            w_state_nxt = w_succ;
            w_cnt_nxt   = (w_succ == S_IDLE) ? '0 : (r_hold - HOLD_W'(1));
        end else begin
            w_cnt_nxt = r_cnt - HOLD_W'(1);
        end
    end

    // Output logic: decoded from the next state so the registered outputs line up with it.
    always_comb begin
        w_ab_nxt = 2'b00;
        unique case (w_state_nxt)
            S_PH1:   w_ab_nxt = (w_kind_nxt == K_EXIT) ? 2'b01 : 2'b10;
            S_PH2:   w_ab_nxt = 2'b11;
            S_PH3:   w_ab_nxt = 2'b10;
            default: w_ab_nxt = 2'b00;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_GUARD) && (w_cnt_nxt == '0);
        w_err_nxt  = w_idle_start && (kind == K_RSVD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_ent  <= '0;
            r_ext  <= '0;
        end else begin
            r_a    <= w_ab_nxt[1];
            r_b    <= w_ab_nxt[0];
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            // Counts become visible together with the done pulse; they saturate.
            if (w_done_nxt && (w_kind_nxt == K_ENTRY) && (r_ent != CNT_MAX))
                r_ent <= r_ent + COUNT_W'(1);
            if (w_done_nxt && (w_kind_nxt == K_EXIT) && (r_ext != CNT_MAX))
                r_ext <= r_ext + COUNT_W'(1);
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cmd_err     = r_err;
    assign enter_count = r_ent;
    assign exit_count  = r_ext;

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Directed bench for sensor_pattern_gen: table of passages, reset/back-to-back
// sequences, and a random run checked against a simple meter decoder.
module tb_sensor_pattern_gen;

    logic        clk = 1'b0;
    logic        reset, start, start2;
    logic [1:0]  kind;
    logic [15:0] hold;
    logic        a, b, busy, done, cmd_err;
    logic [7:0]  enter_count, exit_count;
    logic        a2, b2, busy2, done2, cmd_err2;
    logic [1:0]  enter_count2, exit_count2;

    int n_chk = 0;
    int n_pass = 0;

    sensor_pattern_gen #(.HOLD_W(16), .COUNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .kind(kind), .hold(hold),
        .a(a), .b(b), .busy(busy), .done(done), .cmd_err(cmd_err),
        .enter_count(enter_count), .exit_count(exit_count)
    );

    sensor_pattern_gen #(.HOLD_W(16), .COUNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start2), .kind(kind), .hold(hold),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .cmd_err(cmd_err2),
        .enter_count(enter_count2), .exit_count(exit_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] hold;
        int          h;
        int          nph;
        logic [7:0]  ph;
        int          pulse_at;
        int          d_ent;
        int          d_ext;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    // Gray-adjacency monitor and reference meter decoder for the random run.
    logic       mon_en = 1'b0;
    logic [1:0] prev_ab = 2'b00;
    logic [5:0] m_seq = '0;
    int         m_len = 0;
    int         m_ent = 0;
    int         m_ext = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("gray", {30'd0, (prev_ab ^ {a, b}) == 2'b11}, 32'd0);
            if ({a, b} != prev_ab) begin
                if ({a, b} == 2'b00) begin
                    if (m_len == 3 && m_seq == 6'b10_11_10) m_ent++;
                    if (m_len == 3 && m_seq == 6'b01_11_10) m_ext++;
                    m_seq = '0;
                    m_len = 0;
                end else begin
                    m_seq = {m_seq[3:0], a, b};
                    m_len++;
                end
            end
        end
        prev_ab = {a, b};
    end

    initial begin
        int exp_ent, exp_ext, total, idx;
        logic [1:0] exp_ab;
        int sat_exp[4];
        sat_exp = '{1, 2, 3, 3};

        //              kind   hold h nph ph          pulse dE dX err
        vecs[0] = '{2'b00, 16'd3, 3, 4, 8'b10_11_10_00, 0, 1, 0, 1'b0};
        vecs[1] = '{2'b01, 16'd0, 1, 3, 8'b01_11_10_00, 0, 0, 1, 1'b0};
        vecs[2] = '{2'b10, 16'd2, 2, 1, 8'b10_00_00_00, 0, 0, 0, 1'b0};
        vecs[3] = '{2'b11, 16'd5, 1, 0, 8'b00_00_00_00, 0, 0, 0, 1'b1};
        vecs[4] = '{2'b00, 16'd3, 3, 4, 8'b10_11_10_00, 2, 1, 0, 1'b0};
        vecs[5] = '{2'b01, 16'd2, 2, 3, 8'b01_11_10_00, 0, 0, 1, 1'b0};
        vecs[6] = '{2'b00, 16'd1, 1, 4, 8'b10_11_10_00, 0, 1, 0, 1'b0};

        reset = 1'b1; start = 1'b0; start2 = 1'b0; kind = 2'b00; hold = 16'd0;
        step(); step();
        reset = 1'b0;
        chk("reset_state", {a, b, busy, done, cmd_err, enter_count, exit_count}, 0);

        exp_ent = 0; exp_ext = 0;
        for (int v = 0; v < 7; v++) begin
            kind = vecs[v].kind; hold = vecs[v].hold; start = 1'b1;
            step();
            start = 1'b0; kind = 2'b00; hold = 16'hFFFF;
            if (vecs[v].err) begin
                chk("rsvd_err", {a, b, busy, cmd_err}, 4'b0001);
                step();
                chk("rsvd_err_clr", {a, b, busy, cmd_err}, 4'b0000);
            end else begin
                total = (vecs[v].nph + 1) * vecs[v].h;
                for (int c = 1; c <= total; c++) begin
                    if (c > 1) step();
                    start = (c == vecs[v].pulse_at);
                    if (c == vecs[v].pulse_at) kind = 2'b01;
                    idx = (c - 1) / vecs[v].h;
                    exp_ab = (idx < vecs[v].nph) ? 2'((vecs[v].ph >> (6 - 2 * idx)) & 8'h3) : 2'b00;
                    chk($sformatf("vec%0d_c%0d", v, c), {a, b, busy, done, cmd_err},
                        {exp_ab, 1'b1, (c == total), 1'b0});
                end
                step();
                start = 1'b0; kind = 2'b00;
                exp_ent += vecs[v].d_ent;
                exp_ext += vecs[v].d_ext;
                chk($sformatf("vec%0d_idle", v), {a, b, busy, done}, 4'b0000);
                chk($sformatf("vec%0d_ent", v), enter_count, exp_ent);
                chk($sformatf("vec%0d_ext", v), exit_count, exp_ext);
            end
        end

        // Reset mid-passage: entry hold=3, reset seen at the end of cycle 5.
        kind = 2'b00; hold = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        chk("pre_reset_ab", {a, b, busy}, 3'b111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset", {a, b, busy, done, cmd_err, enter_count, exit_count}, 0);
        step();
        chk("post_reset_idle", {a, b, busy}, 3'b000);

        // Back-to-back entries on the 2-bit-counter instance.
        kind = 2'b00; hold = 16'd1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 1; c <= 5; c++) begin
                if (c > 1) step();
                idx = c - 1;
                exp_ab = (idx < 4) ? 2'((8'b10_11_10_00 >> (6 - 2 * idx)) & 8'h3) : 2'b00;
                chk($sformatf("b2b%0d_c%0d", p, c), {a2, b2, busy2, done2}, {exp_ab, 1'b1, (c == 5)});
            end
            step();
            chk($sformatf("b2b%0d_gap", p), {busy2, done2}, 2'b00);
            chk($sformatf("b2b%0d_cnt", p), enter_count2, sat_exp[p]);
            if (p < 3) begin
                start2 = 1'b1;
                step();
                start2 = 1'b0;
            end
        end

        // Random passages decoded by the meter model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            kind = 2'($urandom_range(0, 3));
            hold = 16'($urandom_range(0, 3));
            start = 1'b1;
            step();
            start = 1'b0;
            if (kind != 2'b11) begin
                for (int k = 0; k < 100 && !done; k++) step();
                if (!done) begin
                    chk("rand_timeout", 0, 1);
                    break;
                end
                step();
            end
        end
        step(); step();
        mon_en = 1'b0;
        chk("rand_enter", enter_count, m_ent);
        chk("rand_exit", exit_count, m_ext);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
